// File: rtl/game_timer_pkg.sv
// Shared constants for the game tick timer: divisor width, preset table and
// the per-cycle event classification used by the count logic.
package game_timer_pkg;

    localparam int DIV_W     = 28;
    localparam int MAX_RATES = 8;

    // Unused slots default to 1; they are only reachable while speed_err is set.
    localparam logic [DIV_W-1:0] DIV_TABLE [MAX_RATES] = '{
        28'd1, 28'd50_000_000, 28'd25_000_000, 28'd12_500_000,
        28'd5_000_000, 28'd1, 28'd1, 28'd1
    };

    typedef enum logic [1:0] {
        EV_NONE    = 2'd0,
        EV_CLEAR   = 2'd1,
        EV_ADVANCE = 2'd2
    } tick_ev_t;

    function automatic logic [DIV_W-1:0] scale_div(input logic [DIV_W-1:0] div,
                                                   input int unsigned    scale);
        int unsigned q;
        q = (scale == 0) ? 32'(div) : 32'(div) / scale;
        return (q == 0) ? DIV_W'(1) : DIV_W'(q);
    endfunction

endpackage

// File: rtl/rate_prescaler.sv
// Down-counting prescaler: reloads divisor-1 on load or after reaching zero,
// holds on request, and flags expiry combinationally in the zero cycle.
module rate_prescaler
    import game_timer_pkg::*;
(
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic             load,
    input  logic             hold,
    input  logic [DIV_W-1:0] divisor,
    output logic             expire
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // Load wins over hold so a clear or rate change under freeze still restarts the period.
    always_comb begin
        cnt_d  = cnt_q;
        expire = 1'b0;
        if (load) begin
            cnt_d = divisor - DIV_W'(1);
        end else if (!hold) begin
            if (cnt_q == '0) begin
                expire = 1'b1;
                cnt_d  = divisor - DIV_W'(1);
            end else begin
                cnt_d = cnt_q - DIV_W'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_tick_timer.sv
// Game tick timer: selectable-rate prescaler driving a modulo-WRAP tick count,
// with freeze/single-step, synchronous clear and illegal-rate detection.
module game_tick_timer
    import game_timer_pkg::*;
#(
    parameter int          CNT_W     = 4,
    parameter int          WRAP      = 10,
    parameter int          NUM_RATES = 5,
    parameter int unsigned DIV_SCALE = 1
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic [2:0]       speed_sel,
    input  logic             freeze,
    input  logic             clear,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output logic             tick,
    output logic             wrap,
    output logic             speed_err
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WRAP - 1);
    localparam logic [3:0]       RATES_L  = 4'(NUM_RATES);

    logic [DIV_W-1:0] div_tab [MAX_RATES];

    for (genvar i = 0; i < MAX_RATES; i++) begin : g_div
        assign div_tab[i] = scale_div(DIV_TABLE[i], DIV_SCALE);
    end

    logic [2:0]       sel_q, sel_d;
    logic             step_q, step_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic             pre_load;
    logic             pre_hold;
    logic             pre_expire;
    logic             step_rise;
    tick_ev_t         ev;

    rate_prescaler u_prescaler (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .load     (pre_load),
        .hold     (pre_hold),
        .divisor  (div_tab[speed_sel]),
        .expire   (pre_expire)
    );

    always_comb begin
        sel_d     = speed_sel;
        step_d    = step;
        err_d     = ({1'b0, speed_sel} >= RATES_L);
        pre_load  = clear | (speed_sel != sel_q);
        pre_hold  = freeze | err_d;
        step_rise = step & ~step_q & freeze;

        // Clear beats freeze/step, which beats prescaler expiry; nothing advances on a bad rate.
        ev = EV_NONE;
        if (clear) begin
            ev = EV_CLEAR;
        end else if (!err_d) begin
            if (freeze) begin
                if (step_rise) ev = EV_ADVANCE;
            end else if (pre_expire) begin
                ev = EV_ADVANCE;
            end
        end

        count_d = count_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        case (ev)
            EV_CLEAR: count_d = '0;
            EV_ADVANCE: begin
                tick_d = 1'b1;
                if (count_q == LAST_CNT) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sel_q   <= '0;
            step_q  <= 1'b0;
            count_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            step_q  <= step_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign count     = count_q;
    assign tick      = tick_q;
    assign wrap      = wrap_q;
    assign speed_err = err_q;

endmodule

// File: tb/tb_game_tick_timer.sv
// Self-checking bench for game_tick_timer with scaled-down divisors (1/50/25/12/5).
module tb_game_tick_timer;

    localparam int SCALE = 1_000_000;
    localparam int WRAPV = 10;
    localparam int RATES = 5;

    logic       CLOCK_50 = 1'b0;
    logic       resetn   = 1'b0;
    logic [2:0] speed_sel = 3'd0;
    logic       freeze   = 1'b0;
    logic       clear    = 1'b0;
    logic       step     = 1'b0;
    logic [3:0] count;
    logic       tick;
    logic       wrap;
    logic       speed_err;

    int checks   = 0;
    int failures = 0;

    // Reference model: cycles left before the next expiry, plus the tick count.
    int m_left, m_prev_sel, m_prev_step, m_count;
    bit m_tick, m_wrap, m_err;
    int tick_seen, wrap_seen;

    game_tick_timer #(
        .CNT_W     (4),
        .WRAP      (WRAPV),
        .NUM_RATES (RATES),
        .DIV_SCALE (SCALE)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .speed_sel (speed_sel),
        .freeze    (freeze),
        .clear     (clear),
        .step      (step),
        .count     (count),
        .tick      (tick),
        .wrap      (wrap),
        .speed_err (speed_err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    function automatic int period_of(input int sel);
        int unsigned presets [RATES];
        int d;
        presets = '{1, 50_000_000, 25_000_000, 12_500_000, 5_000_000};
        if (sel >= RATES) return 1;
        d = int'(presets[sel] / SCALE);
        return (d < 1) ? 1 : d;
    endfunction

    task automatic model_reset();
        m_left = 0; m_prev_sel = 0; m_prev_step = 0; m_count = 0;
        m_tick = 0; m_wrap = 0; m_err = 0;
    endtask

    task automatic model_edge(input int sel, input bit frz, input bit clr, input bit stp);
        bit fire, err, adv;
        fire = 0;
        err  = (sel >= RATES);
        if (clr || sel != m_prev_sel) m_left = period_of(sel) - 1;
        else if (!(frz || err)) begin
            if (m_left == 0) begin
                fire = 1;
                m_left = period_of(sel) - 1;
            end else m_left--;
        end
        if (clr) begin
            m_count = 0; m_tick = 0; m_wrap = 0;
        end else begin
            adv    = !err && (frz ? (stp && !m_prev_step) : fire);
            m_tick = adv;
            m_wrap = adv && (m_count == WRAPV - 1);
            if (adv) m_count = (m_count + 1) % WRAPV;
        end
        m_prev_sel  = sel;
        m_prev_step = stp;
        m_err       = err;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge CLOCK_50);
        model_edge(int'(speed_sel), freeze, clear, step);
        #1;
        if (tick === 1'b1) tick_seen++;
        if (wrap === 1'b1) wrap_seen++;
        chk("count", int'(count), m_count);
        chk("tick", int'(tick), int'(m_tick));
        chk("wrap", int'(wrap), int'(m_wrap));
        chk("speed_err", int'(speed_err), int'(m_err));
    endtask

    task automatic measure(input string tag, input int exp_n);
        int n;
        n = -1;
        for (int i = 1; i <= exp_n + 20 && n < 0; i++) begin
            cycle();
            if (tick === 1'b1) n = i;
        end
        chk(tag, n, exp_n);
    endtask

    initial begin
        int c0, n;
        model_reset();
        tick_seen = 0; wrap_seen = 0;

        #5;
        chk("rst_count", int'(count), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_wrap", int'(wrap), 0);
        chk("rst_err", int'(speed_err), 0);
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        resetn = 1'b1;

        // Fastest rate: count advances every cycle and wraps once in 12 cycles.
        speed_sel = 3'd0;
        for (int i = 0; i < 12; i++) cycle();
        chk("fast_count_end", int'(count), 2);
        chk("fast_ticks", tick_seen, 12);
        chk("fast_wraps", wrap_seen, 1);

        // 0.1 s preset, then a mid-period switch to 0.5 s.
        speed_sel = 3'd4;
        cycle();
        measure("p4_first", 5);
        measure("p4_period", 5);
        cycle(); cycle();
        speed_sel = 3'd2;
        cycle();
        measure("switch_to_2", 25);

        // Freeze at 1 s, then single-step three times.
        speed_sel = 3'd1;
        freeze    = 1'b1;
        cycle();
        c0 = m_count;
        tick_seen = 0;
        for (int i = 0; i < 100; i++) cycle();
        chk("frozen_count", int'(count), c0);
        chk("frozen_ticks", tick_seen, 0);
        for (int i = 0; i < 3; i++) begin
            step = 1'b1; cycle();
            step = 1'b0; cycle();
        end
        chk("step_count", int'(count), (c0 + 3) % WRAPV);
        chk("step_ticks", tick_seen, 3);
        step = 1'b1; freeze = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        step = 1'b0;

        // Clear coincident with an expiry at count 9.
        speed_sel = 3'd0;
        n = 0;
        cycle();
        while (m_count != WRAPV - 1 && n < 30) begin
            cycle();
            n++;
        end
        chk("reach_nine", int'(count), WRAPV - 1);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        chk("clear_count", int'(count), 0);
        chk("clear_tick", int'(tick), 0);
        chk("clear_wrap", int'(wrap), 0);

        // Illegal preset: error flag and no ticks, then recover to 0.25 s.
        speed_sel = 3'd6;
        tick_seen = 0;
        for (int i = 0; i < 200; i++) cycle();
        chk("bad_rate_err", int'(speed_err), 1);
        chk("bad_rate_ticks", tick_seen, 0);
        speed_sel = 3'd3;
        cycle();
        measure("recover_to_3", 12);

        // Reset mid-period at count 7.
        speed_sel = 3'd4;
        n = 0;
        cycle();
        while (m_count != 7 && n < 80) begin
            cycle();
            n++;
        end
        chk("reach_seven", int'(count), 7);
        cycle(); cycle();
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_tick", int'(tick), 0);
        chk("async_rst_wrap", int'(wrap), 0);
        chk("async_rst_err", int'(speed_err), 0);
        model_reset();
        #5 resetn = 1'b1;
        cycle();
        measure("post_reset_first", 5);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) speed_sel = 3'($urandom_range(0, 7));
            else if ($urandom_range(0, 29) == 0) speed_sel = 3'd0;
            freeze = ($urandom_range(0, 9) == 0) ? ~freeze : freeze;
            clear  = ($urandom_range(0, 39) == 0);
            step   = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_tick_timer.md
GAME_TICK_TIMER -- requirements
Module: game_tick_timer

Interface
REQ-001 Parameter CNT_W, default 4: width of the tick count output.
REQ-002 Parameter WRAP, default 10: count modulus, legal range 2..2**CNT_W.
REQ-003 Parameter NUM_RATES, default 5: number of rate presets in use, legal range 1..8.
REQ-004 Parameter DIV_SCALE, default 1: every preset divisor is divided by this value (integer division, floored to 1); used to shorten periods in simulation.
REQ-005 CLOCK_50 input 1: sole clock, 50 MHz.
REQ-006 resetn input 1: reset, asynchronous assert, active-low.
REQ-007 speed_sel input 3: rate preset index.
REQ-008 freeze input 1: level; while high, the prescaler and count hold.
REQ-009 clear input 1: level, synchronous; forces count to 0 and restarts the prescaler.
REQ-010 step input 1: single-step request, honoured only while freeze is high.
REQ-011 count output CNT_W: current tick count.
REQ-012 tick output 1: one-cycle pulse on each count advance.
REQ-013 wrap output 1: one-cycle pulse when count goes from WRAP-1 to 0.
REQ-014 speed_err output 1: high while speed_sel >= NUM_RATES.

Function
REQ-015 Preset divisors before scaling SHALL be: idx0=1 (every cycle), idx1=50_000_000 (1 s), idx2=25_000_000 (0.5 s), idx3=12_500_000 (0.25 s), idx4=5_000_000 (0.1 s).
REQ-016 The prescaler SHALL count down from D-1 to 0, where D is the scaled divisor of the selected preset, then reload D-1; an expiry is a cycle in which the prescaler is at 0.
REQ-017 On an expiry with freeze low, count SHALL advance by 1, and tick SHALL be high on the following cycle.
REQ-018 Count and tick SHALL update on the same clock edge; latency from expiry to tick is exactly 1 cycle.
REQ-019 Count SHALL wrap from WRAP-1 to 0, asserting wrap together with that tick; count SHALL never hold a value >= WRAP.
REQ-020 Each edge on which speed_sel differs from its registered previous value SHALL reload the prescaler to D_new-1, with no expiry in that cycle.
REQ-021 While speed_sel >= NUM_RATES: speed_err is high, the prescaler holds, and no ticks occur; on return to a legal value, behaviour follows REQ-020.
REQ-022 A step rising edge (0->1, registered) with freeze high SHALL advance count by 1 and pulse tick (and wrap when at WRAP-1); step is ignored while freeze is low.
REQ-023 Priority SHALL be clear > freeze/step > expiry.
REQ-024 Clear with freeze high SHALL still zero count; the prescaler reloads and holds.
REQ-025 In a clear cycle, tick and wrap SHALL be 0 on the next cycle, even if an expiry coincides.
REQ-026 Releasing freeze SHALL resume the prescaler from its held value; there are no lost or duplicated ticks.

Reset
REQ-027 When resetn is low, all outputs SHALL be asynchronously forced: count=0, tick=0, wrap=0, speed_err=0.
REQ-028 Reset SHALL also set the prescaler to 0, the registered speed_sel to 0, and the registered step to 0.
REQ-029 After resetn deassertion, the first expiry SHALL follow REQ-020 semantics for the current speed_sel.
REQ-030 Reset mid-period SHALL discard the partial prescaler value.

Structure
REQ-031 Package game_timer_pkg SHALL hold DIV_W=28, MAX_RATES=8, and the preset divisor table constant.
REQ-032 Sub-module rate_prescaler SHALL contain the down-counter, the reload, the hold, and the expiry flag, with ports CLOCK_50, resetn, load, hold, divisor[DIV_W-1:0], and expire.
REQ-033 The top level SHALL contain the speed-change detect, the step edge detect, the count/wrap logic, and the output registers.

Verification (DIV_SCALE=1_000_000, giving divisors 1/50/25/12/5)
REQ-034 speed_sel=0, 12 cycles -> count steps 1..9,0,1,2 every cycle; wrap pulses once.
REQ-035 speed_sel=4 -> tick every 5 cycles; switch to 2 mid-period -> next tick exactly 25 cycles after the switch edge.
REQ-036 freeze=1 for 100 cycles at speed_sel=1 -> count constant, no tick; 3 step pulses -> count +3 with 3 ticks.
REQ-037 count=9, clear coincident with expiry -> count=0, tick=0, wrap=0.
REQ-038 speed_sel=6 -> speed_err=1 and no ticks for 200 cycles; set to 3 -> first tick after 12 cycles.
REQ-039 Assert resetn=0 mid-period at count=7 -> outputs 0 with no clock edge; after release, the first tick arrives a full period later.
